// File: rtl/s5_pll_lock_monitor.sv
// PLL reset sequencer and lock qualifier for the Stratix V PLL wrapper, running on refclk.
// Define S5_PLL_LOCK_MON_TIMEOUT_EN to build the acquisition timeout, retry counter and FAIL state.
module s5_pll_lock_monitor #(
    parameter int unsigned RST_PULSE_CYCLES    = 16,
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
    parameter int unsigned MAX_RETRIES         = 4,
    parameter int unsigned LOSS_CNT_W          = 8
) (
    input  logic                  refclk,
    input  logic                  rst,
    input  logic                  pll_locked,
    input  logic                  force_relock,
    input  logic                  clr_loss,
    output logic                  pll_rst,
    output logic                  pll_ready,
    output logic                  dn_rst,
    output logic                  fail,
    output logic [3:0]            retry_cnt,
    output logic [LOSS_CNT_W-1:0] loss_cnt
);
    localparam int unsigned PULSE_W  = (RST_PULSE_CYCLES > 1) ? $clog2(RST_PULSE_CYCLES) : 1;
    localparam int unsigned STABLE_W = (LOCK_STABLE_CYCLES > 1) ? $clog2(LOCK_STABLE_CYCLES) : 1;
    localparam logic [PULSE_W-1:0]  PULSE_LAST  = PULSE_W'(RST_PULSE_CYCLES - 1);
    localparam logic [STABLE_W-1:0] STABLE_LAST = STABLE_W'(LOCK_STABLE_CYCLES - 1);

    if (RST_PULSE_CYCLES < 2 || LOCK_STABLE_CYCLES < 1 || LOCK_TIMEOUT_CYCLES < 1 ||
        MAX_RETRIES < 1 || MAX_RETRIES > 15 || LOSS_CNT_W < 1) begin : g_param_check
        $error("s5_pll_lock_monitor: parameter out of range");
    end

    typedef enum logic [2:0] {
        ST_RESET_PLL,
        ST_WAIT_LOCK,
        ST_QUALIFY,
        ST_RUN,
        ST_FAIL
    } state_t;

    state_t                  state_q, state_d;
    logic                    lock_meta, lock_s;
    logic [PULSE_W-1:0]      pulse_q, pulse_d;
    logic [STABLE_W-1:0]     stable_q, stable_d;
    logic [LOSS_CNT_W-1:0]   loss_d;
    logic                    loss_evt;
    logic                    pll_rst_d, pll_ready_d;

    // Two-flop synchronizer; lock_meta is the only sampler of the asynchronous pll_locked.
    always_ff @(posedge refclk) begin
        if (rst) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= pll_locked;
            lock_s    <= lock_meta;
        end
    end

`ifdef S5_PLL_LOCK_MON_TIMEOUT_EN
    localparam int unsigned ACQ_W = (LOCK_TIMEOUT_CYCLES > 1) ? $clog2(LOCK_TIMEOUT_CYCLES) : 1;
    localparam logic [ACQ_W-1:0] ACQ_LAST  = ACQ_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [3:0]       RETRY_MAX = 4'(MAX_RETRIES);

    logic [ACQ_W-1:0] acq_q, acq_d;
    logic [3:0]       retry_q, retry_d;
    logic             fail_q, fail_d;

    always_ff @(posedge refclk) begin
        if (rst) begin
            acq_q   <= '0;
            retry_q <= '0;
            fail_q  <= 1'b0;
        end else begin
            acq_q   <= acq_d;
            retry_q <= retry_d;
            fail_q  <= fail_d;
        end
    end

    assign retry_cnt = retry_q;
    assign fail      = fail_q;
`else
    assign retry_cnt = 4'd0;
    assign fail      = 1'b0;
`endif

    // State, timers and registered Moore outputs.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q   <= ST_RESET_PLL;
            pulse_q   <= '0;
            stable_q  <= '0;
            loss_cnt  <= '0;
            pll_rst   <= 1'b1;
            pll_ready <= 1'b0;
            dn_rst    <= 1'b1;
        end else begin
            state_q   <= state_d;
            pulse_q   <= pulse_d;
            stable_q  <= stable_d;
            loss_cnt  <= loss_d;
            pll_rst   <= pll_rst_d;
            pll_ready <= pll_ready_d;
            dn_rst    <= ~pll_ready_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pulse_d  = pulse_q;
        stable_d = stable_q;
        loss_evt = 1'b0;
`ifdef S5_PLL_LOCK_MON_TIMEOUT_EN
        acq_d    = '0;
        retry_d  = retry_q;
`endif

        case (state_q)
            ST_RESET_PLL: begin
                if (pulse_q == PULSE_LAST) begin
                    state_d = ST_WAIT_LOCK;
                end else begin
                    pulse_d = pulse_q + PULSE_W'(1);
                end
            end
            ST_WAIT_LOCK: begin
                if (force_relock) begin
                    state_d = ST_RESET_PLL;
                end else if (lock_s) begin
                    state_d  = ST_QUALIFY;
                    stable_d = '0;
                end
            end
            ST_QUALIFY: begin
                if (force_relock) begin
                    state_d = ST_RESET_PLL;
                end else if (!lock_s) begin
                    state_d = ST_WAIT_LOCK;
                end else if (stable_q == STABLE_LAST) begin
                    state_d = ST_RUN;
`ifdef S5_PLL_LOCK_MON_TIMEOUT_EN
                    retry_d = '0;
`endif
                end else begin
                    stable_d = stable_q + STABLE_W'(1);
                end
            end
            ST_RUN: begin
                // A loss coinciding with force_relock is still counted.
                if (!lock_s) begin
                    state_d  = ST_RESET_PLL;
                    loss_evt = 1'b1;
                end else if (force_relock) begin
                    state_d = ST_RESET_PLL;
                end
            end
`ifdef S5_PLL_LOCK_MON_TIMEOUT_EN
            ST_FAIL: begin
                if (force_relock) begin
                    state_d = ST_RESET_PLL;
                    retry_d = '0;
                end
            end
`endif
            default: state_d = ST_RESET_PLL;
        endcase

`ifdef S5_PLL_LOCK_MON_TIMEOUT_EN
        // Acquisition budget spans WAIT_LOCK and QUALIFY; expiry overrides every other transition.
        if (state_q == ST_WAIT_LOCK || state_q == ST_QUALIFY) begin
            if (acq_q == ACQ_LAST) begin
                retry_d = retry_q + 4'd1;
                state_d = (retry_d == RETRY_MAX) ? ST_FAIL : ST_RESET_PLL;
            end else begin
                acq_d = acq_q + ACQ_W'(1);
            end
        end
`endif

        if (state_d == ST_RESET_PLL && state_q != ST_RESET_PLL) begin
            pulse_d = '0;
        end

        loss_d = loss_cnt;
        if (clr_loss) begin
            loss_d = loss_evt ? LOSS_CNT_W'(1) : '0;
        end else if (loss_evt && loss_cnt != '1) begin
            loss_d = loss_cnt + LOSS_CNT_W'(1);
        end

        pll_rst_d   = (state_d == ST_RESET_PLL) || (state_d == ST_FAIL);
        pll_ready_d = (state_d == ST_RUN);
`ifdef S5_PLL_LOCK_MON_TIMEOUT_EN
        fail_d      = (state_d == ST_FAIL);
`endif
    end

endmodule

// File: tb/tb_s5_pll_lock_monitor.sv
// Directed bench for s5_pll_lock_monitor: lock, chatter, loss, saturation, timeout/fail, mid-run reset.
module tb_s5_pll_lock_monitor;
    localparam int unsigned LW = 2;

    logic          refclk = 1'b0;
    logic          rst;
    logic          pll_locked;
    logic          force_relock;
    logic          clr_loss;
    logic          pll_rst;
    logic          pll_ready;
    logic          dn_rst;
    logic          fail;
    logic [3:0]    retry_cnt;
    logic [LW-1:0] loss_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    s5_pll_lock_monitor #(
        .RST_PULSE_CYCLES   (4),
        .LOCK_STABLE_CYCLES (8),
        .LOCK_TIMEOUT_CYCLES(64),
        .MAX_RETRIES        (2),
        .LOSS_CNT_W         (LW)
    ) dut (
        .refclk      (refclk),
        .rst         (rst),
        .pll_locked  (pll_locked),
        .force_relock(force_relock),
        .clr_loss    (clr_loss),
        .pll_rst     (pll_rst),
        .pll_ready   (pll_ready),
        .dn_rst      (dn_rst),
        .fail        (fail),
        .retry_cnt   (retry_cnt),
        .loss_cnt    (loss_cnt)
    );

    always #5 refclk = ~refclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge refclk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pll_rst"},   32'(pll_rst),   32'd1);
        check({tag, "_dn_rst"},    32'(dn_rst),    32'd1);
        check({tag, "_pll_ready"}, 32'(pll_ready), 32'd0);
        check({tag, "_fail"},      32'(fail),      32'd0);
        check({tag, "_retry_cnt"}, 32'(retry_cnt), 32'd0);
        check({tag, "_loss_cnt"},  32'(loss_cnt),  32'd0);
    endtask

    // Ticks until pll_ready is seen; returns max_cycles+1 if it never rises.
    task automatic wait_ready(input int max_cycles, output int cycles);
        cycles = 0;
        while (pll_ready !== 1'b1 && cycles <= max_cycles) begin
            tick();
            cycles++;
        end
    endtask

    // Loss seen two edges after the drop, then relock: 4-cycle pulse + sync + 8 stable = 13 edges.
    task automatic lose_and_relock(input string tag, input logic [31:0] exp_loss);
        int cyc;
        pll_locked = 1'b0;
        ticks(3);
        check({tag, "_loss_cnt"}, 32'(loss_cnt), exp_loss);
        check({tag, "_dn_rst"},   32'(dn_rst),   32'd1);
        pll_locked = 1'b1;
        wait_ready(40, cyc);
        check({tag, "_relock_cycles"}, 32'(cyc), 32'd13);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cyc;
        int bad;
        rst          = 1'b1;
        pll_locked   = 1'b0;
        force_relock = 1'b0;
        clr_loss     = 1'b0;
        ticks(3);
        check_reset_outputs("por");

        // Clean lock: 4-cycle PLL reset after release, lock raised 10 cycles after release.
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (pll_rst !== 1'b1) bad++;
        end
        check("pulse_high", 32'(bad), 32'd0);
        tick();
        check("pulse_end", 32'(pll_rst), 32'd0);
        ticks(6);
        pll_locked = 1'b1;
        ticks(10);
        check("lock_ready_early", 32'(pll_ready), 32'd0);
        check("lock_dn_rst_early", 32'(dn_rst), 32'd1);
        tick();
        check("lock_ready", 32'(pll_ready), 32'd1);
        check("lock_dn_rst", 32'(dn_rst), 32'd0);
        check("lock_retry", 32'(retry_cnt), 32'd0);
        check("lock_pll_rst", 32'(pll_rst), 32'd0);

        // Loss in RUN, then relock.
        pll_locked = 1'b0;
        ticks(2);
        check("loss_ready_hold", 32'(pll_ready), 32'd1);
        tick();
        check("loss_ready", 32'(pll_ready), 32'd0);
        check("loss_dn_rst", 32'(dn_rst), 32'd1);
        check("loss_pll_rst", 32'(pll_rst), 32'd1);
        check("loss_cnt1", 32'(loss_cnt), 32'd1);
        pll_locked = 1'b1;
        wait_ready(40, cyc);
        check("relock_cycles", 32'(cyc), 32'd13);

        // force_relock from RUN, then 5-high/1-low chatter never qualifies.
        force_relock = 1'b1;
        tick();
        force_relock = 1'b0;
        check("force_pll_rst", 32'(pll_rst), 32'd1);
        check("force_loss_cnt", 32'(loss_cnt), 32'd1);
        bad = 0;
        for (int p = 0; p < 6; p++) begin
            pll_locked = 1'b1;
            for (int i = 0; i < 5; i++) begin
                tick();
                if (pll_ready !== 1'b0) bad++;
            end
            pll_locked = 1'b0;
            tick();
            if (pll_ready !== 1'b0) bad++;
        end
        check("chatter_no_ready", 32'(bad), 32'd0);
        pll_locked = 1'b1;
        ticks(10);
        check("chatter_ready_early", 32'(pll_ready), 32'd0);
        tick();
        check("chatter_ready", 32'(pll_ready), 32'd1);

        // Loss counter saturation at 3, then clear coinciding with a loss.
        lose_and_relock("loss2", 32'd2);
        lose_and_relock("loss3", 32'd3);
        lose_and_relock("loss4", 32'd3);
        pll_locked = 1'b0;
        ticks(2);
        clr_loss = 1'b1;
        tick();
        clr_loss = 1'b0;
        check("clr_with_loss", 32'(loss_cnt), 32'd1);
        check("clr_with_loss_pll_rst", 32'(pll_rst), 32'd1);
        clr_loss = 1'b1;
        tick();
        clr_loss = 1'b0;
        check("clr_alone", 32'(loss_cnt), 32'd0);

`ifdef S5_PLL_LOCK_MON_TIMEOUT_EN
        // Lock held low: resets 68 cycles apart, then FAIL after the second timeout.
        ticks(2);
        check("to_p1_high", 32'(pll_rst), 32'd1);
        tick();
        check("to_p1_end", 32'(pll_rst), 32'd0);
        bad = 0;
        for (int i = 0; i < 63; i++) begin
            tick();
            if (pll_rst !== 1'b0) bad++;
        end
        check("to_w1_low", 32'(bad), 32'd0);
        tick();
        check("to_p2_pll_rst", 32'(pll_rst), 32'd1);
        check("to_p2_retry", 32'(retry_cnt), 32'd1);
        check("to_p2_fail", 32'(fail), 32'd0);
        ticks(3);
        check("to_p2_high", 32'(pll_rst), 32'd1);
        tick();
        check("to_p2_end", 32'(pll_rst), 32'd0);
        bad = 0;
        for (int i = 0; i < 63; i++) begin
            tick();
            if (pll_rst !== 1'b0 || fail !== 1'b0) bad++;
        end
        check("to_w2_low", 32'(bad), 32'd0);
        tick();
        check("fail_flag", 32'(fail), 32'd1);
        check("fail_retry", 32'(retry_cnt), 32'd2);
        check("fail_pll_rst", 32'(pll_rst), 32'd1);
        check("fail_dn_rst", 32'(dn_rst), 32'd1);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (pll_rst !== 1'b1 || fail !== 1'b1) bad++;
        end
        check("fail_held", 32'(bad), 32'd0);
        force_relock = 1'b1;
        tick();
        force_relock = 1'b0;
        check("fail_exit_retry", 32'(retry_cnt), 32'd0);
        check("fail_exit_fail", 32'(fail), 32'd0);
        check("fail_exit_pll_rst", 32'(pll_rst), 32'd1);
`else
        // Without the timeout build, acquisition waits indefinitely.
        ticks(2);
        check("nto_p1_high", 32'(pll_rst), 32'd1);
        tick();
        check("nto_p1_end", 32'(pll_rst), 32'd0);
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (pll_rst !== 1'b0 || fail !== 1'b0 || retry_cnt !== 4'd0) bad++;
        end
        check("nto_wait_forever", 32'(bad), 32'd0);
        force_relock = 1'b1;
        tick();
        force_relock = 1'b0;
        check("nto_force_pll_rst", 32'(pll_rst), 32'd1);
`endif

        // Reset asserted mid-QUALIFY, then the full sequence repeats.
        pll_locked = 1'b1;
        ticks(7);
        check("qual_pll_rst", 32'(pll_rst), 32'd0);
        check("qual_ready", 32'(pll_ready), 32'd0);
        rst = 1'b1;
        tick();
        check_reset_outputs("midrst");
        ticks(2);
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (pll_rst !== 1'b1) bad++;
        end
        check("re_pulse_high", 32'(bad), 32'd0);
        tick();
        check("re_pulse_end", 32'(pll_rst), 32'd0);
        wait_ready(40, cyc);
        check("re_ready_cycles", 32'(cyc), 32'd9);
        check("re_dn_rst", 32'(dn_rst), 32'd0);
        check("re_retry", 32'(retry_cnt), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/s5_pll_lock_monitor.md
# s5_pll_lock_monitor

Consumer side of the Stratix V PLL wrapper interface. Runs on the PLL reference clock, drives the PLL's `rst` input, and qualifies its asynchronous `locked` output. It holds downstream logic in reset until lock has been stable for a programmable time. On loss of lock or acquisition timeout it re-pulses the PLL reset, counts the events, and flags permanent failure after a bounded number of retries.

## Interface
- `RST_PULSE_CYCLES`, 16: PLL reset pulse width in refclk cycles (≥2).
- `LOCK_STABLE_CYCLES`, 1024: consecutive synchronized-lock cycles required before release (≥1).
- `LOCK_TIMEOUT_CYCLES`, 65536: acquisition budget per attempt, counted in WAIT_LOCK+QUALIFY.
- `MAX_RETRIES`, 4: timed-out attempts tolerated before FAIL (1..15).
- `LOSS_CNT_W`, 8: width of the loss-of-lock counter.
- `refclk` in 1: sole clock (PLL reference clock).
- `rst` in 1: reset; synchronous to `refclk`, active-high.
- `pll_locked` in 1: PLL `locked`; asynchronous to `refclk`.
- `force_relock` in 1: single-cycle request to restart acquisition.
- `clr_loss` in 1: single-cycle clear of `loss_cnt`.
- `pll_rst` out 1: drives PLL `rst`.
- `pll_ready` out 1: lock qualified, high only in RUN.
- `dn_rst` out 1: downstream reset, equal to `~pll_ready`.
- `fail` out 1: retries exhausted, high only in FAIL.
- `retry_cnt` out 4: timed-out attempts since the last successful lock.
- `loss_cnt` out LOSS_CNT_W: saturating count of RUN→loss events.

## Operation
- `pll_locked` passes through a 2-flop synchronizer (`lock_s`). No logic other than the first flop samples it.
- States: RESET_PLL, WAIT_LOCK, QUALIFY, RUN, FAIL. Outputs are Moore decodes of the registered state. `pll_rst`=1 in RESET_PLL and FAIL.
- RESET_PLL: pulse timer counts 0..RST_PULSE_CYCLES-1, then goes to WAIT_LOCK. The acquisition timer is cleared on exit.
- WAIT_LOCK: `lock_s`=1 → QUALIFY with the stable counter cleared.
- QUALIFY: the stable counter increments while `lock_s`=1. `lock_s`=0 → WAIT_LOCK, and the acquisition timer is not cleared. When the counter reaches LOCK_STABLE_CYCLES-1 with `lock_s`=1 → RUN and `retry_cnt` clears.
- Timeout applies in WAIT_LOCK or QUALIFY. When the acquisition timer reaches LOCK_TIMEOUT_CYCLES-1, `retry_cnt` increments. If the new value equals MAX_RETRIES → FAIL; otherwise → RESET_PLL.
- RUN: `lock_s`=0 → RESET_PLL and `loss_cnt` increments, saturating at all-ones.
- `force_relock` in WAIT_LOCK, QUALIFY or RUN → RESET_PLL, with no count change. In FAIL it clears `retry_cnt` and goes to RESET_PLL. In RESET_PLL it is ignored.
- Simultaneous events:
  - Loss and `force_relock` in RUN: the loss is counted.
  - Timeout and `lock_s` drop in QUALIFY: the timeout wins.
  - `clr_loss` with a loss increment: `loss_cnt` becomes 1.
- FAIL is left only by `rst` or `force_relock`.

## Timing
- Reset values: state RESET_PLL, `pll_rst`=1, `dn_rst`=1, `pll_ready`=0, `fail`=0, `retry_cnt`=0, `loss_cnt`=0, all timers and sync flops 0.
- The pulse timer restarts when `rst` deasserts, so the first PLL reset lasts RST_PULSE_CYCLES cycles after the `rst` release plus the reset duration.
- Lock qualification: `pll_locked` is first sampled high at edge 0 and held. `lock_s`=1 after edge 1, QUALIFY after edge 2, and `pll_ready`=1 / `dn_rst`=0 after edge LOCK_STABLE_CYCLES+2.
- Loss: `pll_locked` is first sampled low at edge 0 during RUN. After edge 2: `pll_ready`=0, `dn_rst`=1, `pll_rst`=1, and `loss_cnt` is updated.
- `rst` asserted in any state returns all outputs to their reset values on the next edge.
- A glitch on `pll_locked` shorter than one refclk period while in RUN is either missed or counted as a loss. Both outcomes are legal.

## Configuration
- `S5_PLL_LOCK_MON_TIMEOUT_EN` defined: the acquisition timer, retry logic and FAIL state are built as described above.
- Not defined:
  - The timer and FAIL state are removed, and WAIT_LOCK/QUALIFY wait indefinitely.
  - `fail` and `retry_cnt` are tied to 0.
  - LOCK_TIMEOUT_CYCLES and MAX_RETRIES are ignored.

## Test plan
Bench parameters: RST_PULSE_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=64, MAX_RETRIES=2, macro defined.
- Clean lock: release `rst`, then raise `pll_locked` 10 cycles later → `pll_rst` high for exactly 4 cycles after the release; `pll_ready` rises 10 edges after `pll_locked` is first sampled; `retry_cnt`=0.
- Chatter: `pll_locked` toggles with a 5-cycle high / 1-cycle low pattern, then holds high → no `pll_ready` during the chatter; `pll_ready` rises 10 edges into the stable high.
- Loss in RUN: drop `pll_locked` → `dn_rst`=1 and `pll_rst`=1 two edges later, `loss_cnt` 0→1; on relock, `pll_ready` returns.
- Timeout/fail: hold `pll_locked`=0 → two 4-cycle PLL resets 68 cycles apart, then `fail`=1, `retry_cnt`=2, `pll_rst` held high; `force_relock` → `retry_cnt`=0, RESET_PLL.
- Saturation/clear: LOSS_CNT_W=2, force 4 losses → `loss_cnt`=3; pulse `clr_loss` in the same cycle as a 5th loss → `loss_cnt`=1.
- Mid-operation reset: assert `rst` during QUALIFY → all outputs at reset values on the next edge; the full sequence repeats after release.
